packet_endpoint: RTL and testbench

//  Receive endpoint for packets classified by the upstream decision stage; one

---
 rtl/packet_endpoint.sv | 120 ++++++++++++
 tb/tb_packet_endpoint.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_endpoint.sv
// Receive endpoint: samples a held {payload, ip, port} record, captures each
// new record into a first-word fall-through FIFO, and exposes a read port plus
// saturating accepted/dropped counters.
module packet_endpoint #(
  parameter int DATA_WIDTH    = 256,
  parameter int PAYLOAD_WIDTH = DATA_WIDTH * 3 - 432,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PAYLOAD_WIDTH-1:0] data_in,
  input  logic [31:0]              ip,
  input  logic [15:0]              port,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [PAYLOAD_WIDTH-1:0] rd_data,
  output logic [31:0]              rd_ip,
  output logic [15:0]              rd_port,
  output logic                     full,
  output logic [15:0]              pkt_count,
  output logic [15:0]              drop_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int REC = PAYLOAD_WIDTH + 48;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  // Storage is deliberately not reset; the read port masks it while empty.
  logic [PAYLOAD_WIDTH-1:0] r_mem_data [DEPTH];
  logic [31:0]              r_mem_ip   [DEPTH];
  logic [15:0]              r_mem_port [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [REC-1:0]  r_last_rec;
  logic [15:0]     r_pkt_count;
  logic [15:0]     r_drop_count;

  logic [REC-1:0]  w_rec;
  logic [AW:0]     w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_capture;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  assign w_rec   = {data_in, ip, port};
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == DEPTH_L);
  assign w_empty = (w_count == '0);

  // Capture test is an if-condition so unknown/undriven inputs never capture.
  always_comb begin
    w_capture = 1'b0;
    if ((ip != 32'd0) && (w_rec != r_last_rec)) begin
      w_capture = 1'b1;
    end
  end

  // A same-cycle pop frees a slot, so a capture into a full FIFO is accepted.
  assign w_pop  = rd_en && !w_empty;
  assign w_push = w_capture && (!w_full || w_pop);
  assign w_drop = w_capture && w_full && !w_pop;

  // Pointer, last-record and counter state; reset wins over any capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_last_rec   <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_capture) begin
        r_last_rec <= w_rec;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_pkt_count != 16'hFFFF) begin
          r_pkt_count <= r_pkt_count + 16'd1;
        end
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Tail write of an accepted record.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_data[r_wr_ptr[AW-1:0]] <= data_in;
      r_mem_ip[r_wr_ptr[AW-1:0]]   <= ip;
      r_mem_port[r_wr_ptr[AW-1:0]] <= port;
    end
  end

  // Head entry falls through to the read port; zeros while empty.
  always_comb begin
    rd_data = '0;
    rd_ip   = '0;
    rd_port = '0;
    if (!w_empty) begin
      rd_data = r_mem_data[r_rd_ptr[AW-1:0]];
      rd_ip   = r_mem_ip[r_rd_ptr[AW-1:0]];
      rd_port = r_mem_port[r_rd_ptr[AW-1:0]];
    end
  end

  assign rd_valid   = !w_empty;
  assign full       = w_full;
  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_packet_endpoint.sv
// Bench for packet_endpoint: directed records, a queue-based reference model
// compared on every falling edge, and literal checks at key points.
module tb_packet_endpoint;

  localparam int PW    = 336;
  localparam int DEPTH = 4;
  localparam int RW    = PW + 48;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] data_in;
  logic [31:0]   ip;
  logic [15:0]   port;
  logic          rd_en;
  logic          rd_valid;
  logic [PW-1:0] rd_data;
  logic [31:0]   rd_ip;
  logic [15:0]   rd_port;
  logic          full;
  logic [15:0]   pkt_count;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  packet_endpoint #(.DATA_WIDTH(256), .PAYLOAD_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .ip(ip), .port(port),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ip(rd_ip),
    .rd_port(rd_port), .full(full), .pkt_count(pkt_count),
    .drop_count(drop_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] m_last;
  logic [15:0]   m_pkt;
  logic [15:0]   m_drop;
  bit            drv_z  = 1'b1;
  bit            chk_en = 1'b0;

  // Model advances on the same edge as the DUT using the held inputs.
  always @(posedge clk) begin
    logic [RW-1:0] rec;
    bit cap;
    rec = {data_in, ip, port};
    if (rst) begin
      exp_q.delete();
      m_last = '0;
      m_pkt  = '0;
      m_drop = '0;
      chk_en = 1'b1;
    end else begin
      cap = !drv_z && (ip != 32'd0) && (rec != m_last);
      if (rd_en && exp_q.size() > 0) void'(exp_q.pop_front());
      if (cap) begin
        m_last = rec;
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(rec);
          if (m_pkt != 16'hFFFF) m_pkt = m_pkt + 16'd1;
        end else if (m_drop != 16'hFFFF) begin
          m_drop = m_drop + 16'd1;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        check("cyc_rd_valid", RW'(rd_valid), RW'(1'b0));
        check("cyc_head_empty", {rd_data, rd_ip, rd_port}, '0);
      end else begin
        check("cyc_rd_valid", RW'(rd_valid), RW'(1'b1));
        check("cyc_head", {rd_data, rd_ip, rd_port}, exp_q[0]);
      end
      check("cyc_full", RW'(full), RW'(exp_q.size() == DEPTH));
      check("cyc_pkt", RW'(pkt_count), RW'(m_pkt));
      check("cyc_drop", RW'(drop_count), RW'(m_drop));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_z();
    drv_z   = 1'b1;
    data_in = 'z;
    ip      = 'z;
    port    = 'z;
  endtask

  task automatic set_rec(input logic [PW-1:0] d, input logic [31:0] a,
                         input logic [15:0] p);
    drv_z   = 1'b0;
    data_in = d;
    ip      = a;
    port    = p;
  endtask

  // Distinct record k: ip 0A0000kk, port k, payload patterned from k.
  task automatic set_k(input int k);
    logic [31:0] w;
    w = 32'hA5000000 | 32'(k);
    set_rec({{10{w}}, 16'(k)}, 32'h0A000000 + 32'(k), 16'(k));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [PW-1:0] png;
    png   = 336'h89504E470D0A1A0A;
    png   = png << 272;
    rd_en = 1'b0;
    rst   = 1'b1;
    set_z();
    step(2);
    rst = 1'b0;
    step(10);
    check("idle_rd_valid", RW'(rd_valid), RW'(1'b0));
    check("idle_pkt", RW'(pkt_count), RW'(0));

    // held record for 5 cycles collapses into one entry
    set_rec(png, 32'hC0A80001, 16'h0015);
    step(5);
    check("r0_pkt", RW'(pkt_count), RW'(1));
    check("r0_rd_ip", RW'(rd_ip), RW'(32'hC0A80001));
    check("r0_rd_port", RW'(rd_port), RW'(16'h0015));
    check("r0_rd_data", RW'(rd_data), RW'(png));

    // fill, then drop one
    for (int k = 1; k <= 3; k++) begin
      set_k(k);
      step(2);
    end
    check("fill_full", RW'(full), RW'(1'b1));
    check("fill_pkt", RW'(pkt_count), RW'(4));
    set_k(4);
    step(2);
    check("drop_count", RW'(drop_count), RW'(1));
    check("drop_pkt", RW'(pkt_count), RW'(4));
    check("drop_head", RW'(rd_ip), RW'(32'hC0A80001));

    // capture into full FIFO with simultaneous pop
    set_k(5);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    check("cp_pkt", RW'(pkt_count), RW'(5));
    check("cp_full", RW'(full), RW'(1'b1));
    check("cp_head", RW'(rd_ip), RW'(32'h0A000001));
    step(1);

    // drain, then reads while empty
    rd_en = 1'b1;
    step(6);
    rd_en = 1'b0;
    check("drain_valid", RW'(rd_valid), RW'(1'b0));
    check("drain_data", RW'(rd_data), RW'(0));
    check("drain_full", RW'(full), RW'(1'b0));

    // A, Z, A -> single capture
    set_k(6);
    step(2);
    set_z();
    step(2);
    set_k(6);
    step(2);
    check("aza_pkt", RW'(pkt_count), RW'(6));
    check("aza_ip", RW'(rd_ip), RW'(32'h0A000006));

    // reset with two entries queued; capture on the reset edge ignored
    set_k(7);
    step(2);
    set_k(8);
    rst = 1'b1;
    step(1);
    check("rst_valid", RW'(rd_valid), RW'(1'b0));
    check("rst_pkt", RW'(pkt_count), RW'(0));
    check("rst_drop", RW'(drop_count), RW'(0));
    rst = 1'b0;
    set_z();
    step(2);
    check("post_rst_pkt", RW'(pkt_count), RW'(0));

    // mixed burst: new record every cycle, reads two cycles in three
    for (int i = 0; i < 24; i++) begin
      set_k(20 + i);
      rd_en = (i % 3 != 0);
      step(1);
    end
    set_z();
    rd_en = 1'b1;
    step(8);
    rd_en = 1'b0;
    step(2);
    check("burst_empty", RW'(rd_valid), RW'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
